// File: rtl/spectrum_peak_meter.sv
// spectrum_peak_meter
//   Frame-based spectrum level meter. A prescaler produces a periodic
//   acquisition strobe that restarts the FFT frame. Incoming frequency samples
//   are binned into NUM_BANDS bands, and each band keeps the largest magnitude
//   seen in the current frame. At every frame boundary the per-band maxima are
//   snapshotted. The band levels are then updated one band per cycle,
//   according to the display mode latched at that boundary.
//
// Optional build macro:
//   PEAK_METER_IIR_EN - when defined, mode 2'b11 selects an IIR average
//                       (level - level/4 + snap/4). When undefined, mode 2'b11
//                       behaves as live mode and no averaging logic is built.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-high reset
//   sample_valid frequency sample strobe
//   sample_addr  frequency bin address; the top log2(NUM_BANDS) bits select the band
//   sample_data  unsigned frequency magnitude
//   mode         00 live, 01 peak-hold with decay, 10 freeze, 11 IIR/live
//   band_sel     band shown on level_out / led
//   start_acq    one-cycle frame strobe to the FFT start input
//   frame_done   one-cycle pulse when the band update sweep has completed
//   level_out    registered level of band_sel
//   led          registered thermometer bar of band_sel, LSB first
module spectrum_peak_meter #(
  parameter int PRESC_DIV    = 2500000,
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 10,
  parameter int NUM_BANDS    = 16,
  parameter int LED_W        = 16,
  parameter int DECAY_FRAMES = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sample_valid,
  input  logic [ADDR_W-1:0]            sample_addr,
  input  logic [DATA_W-1:0]            sample_data,
  input  logic [1:0]                   mode,
  input  logic [$clog2(NUM_BANDS)-1:0] band_sel,
  output logic                         start_acq,
  output logic                         frame_done,
  output logic [DATA_W-1:0]            level_out,
  output logic [LED_W-1:0]             led
);

  localparam int BAND_W = $clog2(NUM_BANDS);
  localparam int CNT_W  = $clog2(PRESC_DIV);
  localparam int DEC_W  = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;
  localparam int LIT_W  = $clog2(LED_W + 1);
  localparam int PROD_W = DATA_W + LIT_W;

  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_UPDATE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  genvar gi;

  // ---------------------------------------------------------------------------
  // Frame prescaler
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_reg;
  logic             tick;

  assign tick = (cnt_reg == CNT_W'(PRESC_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg   <= '0;
      start_acq <= 1'b0;
    end else begin
      start_acq <= tick;
      cnt_reg   <= tick ? '0 : cnt_reg + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-frame control latched at the frame boundary: the display mode, and
  // whether this frame's peak-hold pass applies a 1-LSB decay step.
  // ---------------------------------------------------------------------------
  logic [1:0]       mode_l_reg;
  logic [DEC_W-1:0] decay_cnt_reg;
  logic             decay_ok_reg;
  logic             decay_wrap;

  assign decay_wrap = (decay_cnt_reg == DEC_W'(DECAY_FRAMES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_l_reg    <= 2'b00;
      decay_cnt_reg <= '0;
      decay_ok_reg  <= 1'b0;
    end else if (tick) begin
      mode_l_reg    <= mode;
      decay_ok_reg  <= decay_wrap;
      decay_cnt_reg <= decay_wrap ? '0 : decay_cnt_reg + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Update sequencer
  // ---------------------------------------------------------------------------
  state_t            state_reg, state_next;
  logic [BAND_W-1:0] idx_reg, idx_next;
  logic              frame_done_next;
  logic              update_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= ST_ACCUM;
      idx_reg    <= '0;
      frame_done <= 1'b0;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      frame_done <= frame_done_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    frame_done_next = 1'b0;
    update_en       = 1'b0;
    case (state_reg)
      ST_UPDATE: begin
        update_en = 1'b1;
        if (idx_reg == BAND_W'(NUM_BANDS - 1)) begin
          state_next = ST_DONE;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end
      // The extra state registers frame_done one cycle after the last band
      // write. Its level is therefore already visible on level_out when the
      // pulse appears.
      ST_DONE: begin
        frame_done_next = 1'b1;
        state_next      = ST_ACCUM;
      end
      default: ;
    endcase
    // The frame boundary restarts the sweep whatever the current state.
    if (tick) begin
      state_next = ST_UPDATE;
      idx_next   = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-band accumulate / snapshot / level storage
  // ---------------------------------------------------------------------------
  logic [BAND_W-1:0] sample_band;
  logic [DATA_W-1:0] level_arr [NUM_BANDS];
  logic [DATA_W-1:0] snap_arr  [NUM_BANDS];
  logic [DATA_W-1:0] upd_level;
  logic              unused_addr_parity;

  assign sample_band = sample_addr[ADDR_W-1 -: BAND_W];
  // The low address bits only resolve bins within a band.
  assign unused_addr_parity = ^sample_addr;

  generate
    for (gi = 0; gi < NUM_BANDS; gi++) begin : g_band
      logic [DATA_W-1:0] frame_max_reg;
      logic [DATA_W-1:0] snap_reg;
      logic [DATA_W-1:0] level_reg;
      logic              hit;

      assign hit          = sample_valid && (sample_band == BAND_W'(gi));
      assign level_arr[gi] = level_reg;
      assign snap_arr[gi]  = snap_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          frame_max_reg <= '0;
          snap_reg      <= '0;
          level_reg     <= '0;
        end else begin
          if (tick) begin
            // A sample on the boundary edge seeds the new frame. It is never
            // part of the snapshot taken on that edge.
            snap_reg      <= frame_max_reg;
            frame_max_reg <= hit ? sample_data : '0;
          end else if (hit && (sample_data > frame_max_reg)) begin
            frame_max_reg <= sample_data;
          end
          if (update_en && (idx_reg == BAND_W'(gi))) begin
            level_reg <= upd_level;
          end
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Shared level-update datapath for the band being swept
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] cur_level;
  logic [DATA_W-1:0] cur_snap;
  logic [DATA_W-1:0] decayed;

  assign cur_level = level_arr[idx_reg];
  assign cur_snap  = snap_arr[idx_reg];

  always_comb begin
    decayed = cur_level;
    if (decay_ok_reg && (cur_level != '0)) begin
      decayed = cur_level - DATA_W'(1);
    end
    upd_level = cur_snap;
    case (mode_l_reg)
      2'b01:   upd_level = (cur_snap > decayed) ? cur_snap : decayed;
      2'b10:   upd_level = cur_level;
`ifdef PEAK_METER_IIR_EN
      // level - level/4 + snap/4 cannot exceed full scale, so one guard bit
      // is enough and truncation back to DATA_W loses nothing.
      2'b11:   upd_level = DATA_W'({1'b0, cur_level}
                                   - (DATA_W + 1)'(cur_level >> 2)
                                   + (DATA_W + 1)'(cur_snap >> 2));
`endif
      default: upd_level = cur_snap;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Display outputs
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] sel_level;
  logic [LIT_W-1:0]  lit;
  logic [LED_W-1:0]  led_next;

  assign sel_level = level_arr[band_sel];
  assign lit       = LIT_W'((PROD_W'(sel_level) * PROD_W'(LED_W)) >> DATA_W);

  generate
    for (gi = 0; gi < LED_W; gi++) begin : g_led
      assign led_next[gi] = (LIT_W'(gi) < lit);
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_out <= '0;
      led       <= '0;
    end else begin
      level_out <= sel_level;
      led       <= led_next;
    end
  end

endmodule
